// File: rtl/pwm_sched_pkg.sv
// Shared constants and types for the PWM ramp scheduler: channel count,
// FSM state codes and the default neutral control code.
package pwm_sched_pkg;

  localparam int CHAN_COUNT = 3;

  localparam logic [7:0] NEUTRAL_DEFAULT = 8'd0;
  localparam logic [1:0] CHAN_ILLEGAL    = 2'd3;

  // UPDn states are contiguous so a channel index maps straight onto its state.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UPD0 = 2'd1;
  localparam logic [1:0] ST_UPD1 = 2'd2;
  localparam logic [1:0] ST_UPD2 = 2'd3;

  typedef logic [7:0] code_t;
  typedef logic [3:0] step_t;

  function automatic logic [1:0] upd_state(input int idx);
    return ST_UPD0 + 2'(idx);
  endfunction

endpackage

// File: rtl/pwm_slew_step.sv
// One slew step for a single channel: jump when step is zero, otherwise move
// toward the target by at most step codes without overshooting.
module pwm_slew_step
  import pwm_sched_pkg::*;
(
  input  code_t i_cur,
  input  code_t i_target,
  input  step_t i_step,
  output code_t o_next
);

  // Nine bits so the sum cannot wrap and a negative difference shows in bit 8.
  logic [8:0] w_up;
  logic [8:0] w_down;

  assign w_up   = {1'b0, i_cur} + {5'b0, i_step};
  assign w_down = {1'b0, i_cur} - {5'b0, i_step};

  always_comb begin
    o_next = i_cur;
    if (i_step == '0) begin
      o_next = i_target;
    end else if (i_cur < i_target) begin
      o_next = (w_up >= {1'b0, i_target}) ? i_target : w_up[7:0];
    end else if (i_cur > i_target) begin
      o_next = (w_down[8] || (w_down[7:0] <= i_target)) ? i_target : w_down[7:0];
    end
  end

endmodule

// File: rtl/pwm_ramp_scheduler.sv
// Three-channel PWM ramp scheduler: accepts per-channel target/step commands,
// slews each channel once per tick and falls back to NEUTRAL on watchdog expiry.
module pwm_ramp_scheduler
  import pwm_sched_pkg::*;
#(
  parameter int         TICK_DIV   = 50000,
  parameter int         WDOG_TICKS = 500,
  parameter logic [7:0] NEUTRAL    = NEUTRAL_DEFAULT
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_chan,
  input  logic [7:0] cmd_target,
  input  logic [3:0] cmd_step,
  output logic [7:0] pwm_ctrl0,
  output logic [7:0] pwm_ctrl1,
  output logic [7:0] pwm_ctrl2,
  output logic [2:0] busy,
  output logic       wdog_expired,
  output logic       cmd_err
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WDOG_W = $clog2(WDOG_TICKS + 1);
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_TICKS);

  logic [TICK_W-1:0] r_tick_cnt;
  logic [WDOG_W-1:0] r_wdog_cnt;
  logic [1:0]        r_state;
  logic              r_wdog_expired;
  logic              r_cmd_err;
  code_t             r_cur    [CHAN_COUNT];
  code_t             r_target [CHAN_COUNT];
  step_t             r_step   [CHAN_COUNT];

  logic  w_tick;
  logic  w_accept;
  logic  w_legal;
  logic  w_wdog_fire;
  code_t w_sel_cur;
  code_t w_sel_target;
  step_t w_sel_step;
  code_t w_slew_next;

  assign w_tick      = (r_tick_cnt == TICK_LAST);
  // Gated by rst_in so nothing is offered while reset is held.
  assign cmd_ready   = rst_in & (r_state == ST_IDLE) & ~w_tick;
  assign w_accept    = cmd_valid & cmd_ready;
  assign w_legal     = w_accept & (cmd_chan != CHAN_ILLEGAL);
  assign w_wdog_fire = w_tick & ~r_wdog_expired & (r_wdog_cnt == WDOG_LIMIT - 1'b1);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= w_tick ? ST_UPD0 : ST_IDLE;
        ST_UPD0: r_state <= ST_UPD1;
        ST_UPD1: r_state <= ST_UPD2;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Counter parks at zero once expired; only a legal command re-arms it.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_wdog_cnt     <= '0;
      r_wdog_expired <= 1'b0;
    end else if (w_legal) begin
      r_wdog_cnt     <= '0;
      r_wdog_expired <= 1'b0;
    end else if (w_wdog_fire) begin
      r_wdog_cnt     <= '0;
      r_wdog_expired <= 1'b1;
    end else if (w_tick && !r_wdog_expired) begin
      r_wdog_cnt <= r_wdog_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_cmd_err <= 1'b0;
    end else begin
      r_cmd_err <= w_accept & (cmd_chan == CHAN_ILLEGAL);
    end
  end

  always_comb begin
    w_sel_cur    = r_cur[0];
    w_sel_target = r_target[0];
    w_sel_step   = r_step[0];
    case (r_state)
      ST_UPD1: begin
        w_sel_cur    = r_cur[1];
        w_sel_target = r_target[1];
        w_sel_step   = r_step[1];
      end
      ST_UPD2: begin
        w_sel_cur    = r_cur[2];
        w_sel_target = r_target[2];
        w_sel_step   = r_step[2];
      end
      default: ;
    endcase
  end

  pwm_slew_step u_slew (
    .i_cur    (w_sel_cur),
    .i_target (w_sel_target),
    .i_step   (w_sel_step),
    .o_next   (w_slew_next)
  );

  for (genvar gi = 0; gi < CHAN_COUNT; gi++) begin : g_chan
    localparam logic [1:0] CHAN_ID = 2'(gi);
    localparam logic [1:0] ST_MINE = upd_state(gi);

    // Commands and ticks never share a cycle, so the two writers cannot collide.
    always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
        r_target[gi] <= NEUTRAL;
        r_step[gi]   <= '0;
      end else if (w_wdog_fire) begin
        r_target[gi] <= NEUTRAL;
      end else if (w_legal && (cmd_chan == CHAN_ID)) begin
        r_target[gi] <= cmd_target;
        r_step[gi]   <= cmd_step;
      end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
        r_cur[gi] <= NEUTRAL;
      end else if (r_state == ST_MINE) begin
        r_cur[gi] <= w_slew_next;
      end
    end

    assign busy[gi] = (r_cur[gi] != r_target[gi]);
  end

  assign pwm_ctrl0    = r_cur[0];
  assign pwm_ctrl1    = r_cur[1];
  assign pwm_ctrl2    = r_cur[2];
  assign wdog_expired = r_wdog_expired;
  assign cmd_err      = r_cmd_err;

endmodule

// File: tb/tb_pwm_ramp_scheduler.sv
// Self-checking bench for pwm_ramp_scheduler: directed vector table, hand-written
// corner sequences and randomized traffic checked against a cycle-count model.
module tb_pwm_ramp_scheduler;

  // TICK_DIV=4 would leave no tick-free IDLE cycle once the FSM is running,
  // so 8 is used to give a four-cycle command window per tick period.
  localparam int         TD  = 8;
  localparam int         WD  = 3;
  localparam logic [7:0] NEU = 8'd0;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_chan = 2'd0;
  logic [7:0] cmd_target = 8'd0;
  logic [3:0] cmd_step = 4'd0;
  logic [7:0] pwm_ctrl0, pwm_ctrl1, pwm_ctrl2;
  logic [2:0] busy;
  logic       wdog_expired;
  logic       cmd_err;

  pwm_ramp_scheduler #(.TICK_DIV(TD), .WDOG_TICKS(WD), .NEUTRAL(NEU)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_chan     (cmd_chan),
    .cmd_target   (cmd_target),
    .cmd_step     (cmd_step),
    .pwm_ctrl0    (pwm_ctrl0),
    .pwm_ctrl1    (pwm_ctrl1),
    .pwm_ctrl2    (pwm_ctrl2),
    .busy         (busy),
    .wdog_expired (wdog_expired),
    .cmd_err      (cmd_err)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: channel values plus a cycle count since reset release.
  int m_cur [3];
  int m_tgt [3];
  int m_stp [3];
  int m_wd;
  bit m_exp;
  bit m_err;
  int m_cyc;

  typedef struct {
    bit do_cmd;
    int ch;
    int tg;
    int st;
    int chk_ch;
    int exp_pwm;
    bit exp_busy;
    bit exp_wdog;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int slew(input int c, input int t, input int s);
    if (s == 0) return t;
    if (c < t) return (c + s > t) ? t : c + s;
    if (c > t) return (c - s < t) ? t : c - s;
    return c;
  endfunction

  // Period: tick at phase TD-1, then three update cycles; the first period has no updates.
  function automatic bit m_ready();
    int ph;
    ph = m_cyc % TD;
    if (ph == TD - 1) return 1'b0;
    if (m_cyc >= TD && ph <= 2) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [7:0] pwm_of(input int c);
    if (c == 0) return pwm_ctrl0;
    if (c == 1) return pwm_ctrl1;
    return pwm_ctrl2;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cur[i] = int'(NEU);
      m_tgt[i] = int'(NEU);
      m_stp[i] = 0;
    end
    m_wd  = 0;
    m_exp = 1'b0;
    m_err = 1'b0;
    m_cyc = 0;
  endtask

  // Entered and left at posedge+1: drive, compare all outputs, advance model and clock.
  task automatic cyc(input bit v, input int ch, input int tg, input int st, output bit acc);
    logic [29:0] exp_v, act_v;
    int ph, upd;
    cmd_valid  = v;
    cmd_chan   = ch[1:0];
    cmd_target = tg[7:0];
    cmd_step   = st[3:0];
    #1;
    exp_v = {m_ready(), m_cur[0][7:0], m_cur[1][7:0], m_cur[2][7:0],
             m_cur[2] != m_tgt[2], m_cur[1] != m_tgt[1], m_cur[0] != m_tgt[0], m_exp, m_err};
    act_v = {cmd_ready, pwm_ctrl0, pwm_ctrl1, pwm_ctrl2, busy, wdog_expired, cmd_err};
    chk($sformatf("cycle %0d outputs", m_cyc), 64'(act_v), 64'(exp_v));
    acc = v && m_ready();
    ph  = m_cyc % TD;
    upd = (m_cyc >= TD && ph <= 2) ? ph : -1;
    m_err = acc && (ch == 3);
    if (acc && ch < 3) begin
      m_tgt[ch] = tg;
      m_stp[ch] = st;
      m_wd      = 0;
      m_exp     = 1'b0;
    end
    if (ph == TD - 1 && !m_exp) begin
      m_wd++;
      if (m_wd == WD) begin
        m_wd  = 0;
        m_exp = 1'b1;
        for (int i = 0; i < 3; i++) m_tgt[i] = int'(NEU);
      end
    end
    if (upd >= 0) m_cur[upd] = slew(m_cur[upd], m_tgt[upd], m_stp[upd]);
    m_cyc++;
    @(posedge clk_in);
    #1;
  endtask

  task automatic send(input int ch, input int tg, input int st);
    bit acc;
    acc = 1'b0;
    for (int k = 0; k < TD + 4; k++) begin
      cyc(1'b1, ch, tg, st, acc);
      if (acc) break;
    end
    if (!acc) chk("send accepted", 64'd0, 64'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic run_to_upd_done();
    bit acc;
    int guard;
    guard = 0;
    do begin
      cyc(1'b0, 0, 0, 0, acc);
      guard++;
    end while (!((m_cyc % TD) == 3 && m_cyc >= TD) && guard < 3 * TD);
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    #1;
    chk("reset outputs", 64'({cmd_ready, pwm_ctrl0, pwm_ctrl1, pwm_ctrl2, busy, wdog_expired, cmd_err}),
        64'({1'b0, NEU, NEU, NEU, 3'b000, 1'b0, 1'b0}));
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    model_reset();
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    v = tbl[idx];
    if (v.do_cmd) send(v.ch, v.tg, v.st);
    run_to_upd_done();
    chk($sformatf("vec%0d pwm_ctrl%0d", idx, v.chk_ch), 64'(pwm_of(v.chk_ch)), 64'(v.exp_pwm));
    chk($sformatf("vec%0d busy[%0d]", idx, v.chk_ch), 64'(busy[v.chk_ch]), 64'(v.exp_busy));
    chk($sformatf("vec%0d wdog_expired", idx), 64'(wdog_expired), 64'(v.exp_wdog));
  endtask

  initial begin
    bit acc;
    int lows, accepts, e;
    bit r;

    tbl[0]  = '{1, 1, 200, 0,  1, 200, 0, 0};
    tbl[1]  = '{1, 0, 10,  4,  0, 4,   1, 0};
    tbl[2]  = '{1, 0, 10,  4,  0, 8,   1, 0};
    tbl[3]  = '{1, 0, 10,  4,  0, 10,  0, 0};
    tbl[4]  = '{0, 0, 0,   0,  0, 10,  0, 0};
    tbl[5]  = '{0, 0, 0,   0,  0, 6,   1, 1};
    tbl[6]  = '{0, 0, 0,   0,  0, 2,   1, 1};
    tbl[7]  = '{0, 0, 0,   0,  0, 0,   0, 1};
    tbl[8]  = '{1, 2, 240, 0,  2, 240, 0, 0};
    tbl[9]  = '{1, 2, 250, 15, 2, 250, 0, 0};
    tbl[10] = '{1, 2, 5,   15, 2, 235, 1, 0};
    tbl[11] = '{1, 2, 5,   15, 2, 220, 1, 0};

    #2;
    do_reset();

    for (int i = 0; i < 8; i++) run_vec(i);

    // Illegal channel while expired: error pulse only, watchdog left alone.
    send(3, 77, 3);
    chk("cmd_err pulse", 64'(cmd_err), 64'd1);
    chk("wdog held on illegal cmd", 64'(wdog_expired), 64'd1);
    cyc(1'b0, 0, 0, 0, acc);
    chk("cmd_err one cycle", 64'(cmd_err), 64'd0);
    send(1, 0, 0);
    chk("wdog cleared by legal cmd", 64'(wdog_expired), 64'd0);
    run_to_upd_done();

    for (int i = 8; i < 12; i++) run_vec(i);

    // Continue the descent to 5; re-sending keeps the watchdog fed.
    for (int k = 1; k <= 15; k++) begin
      send(2, 5, 15);
      run_to_upd_done();
      e = 220 - 15 * k;
      if (e < 5) e = 5;
      chk($sformatf("descent step %0d", k), 64'(pwm_ctrl2), 64'(e));
    end
    chk("descent done busy[2]", 64'(busy[2]), 64'd0);

    // Valid held across a tick: refused for tick+3 updates, then taken once.
    while ((m_cyc % TD) != TD - 1) cyc(1'b0, 0, 0, 0, acc);
    lows = 0;
    accepts = 0;
    for (int k = 0; k < 10; k++) begin
      r = cmd_ready;
      cyc(1'b1, 1, 33, 0, acc);
      if (r) begin
        accepts++;
        break;
      end
      lows++;
    end
    cmd_valid = 1'b0;
    chk("ready low through tick+upd", 64'(lows), 64'd4);
    chk("held cmd accepted once", 64'(accepts), 64'd1);
    run_to_upd_done();
    chk("held cmd applied", 64'(pwm_ctrl1), 64'd33);

    // Reset in the middle of a ramp, during UPD1.
    send(0, 200, 1);
    run_to_upd_done();
    chk("ramp started", 64'(pwm_ctrl0), 64'd1);
    while ((m_cyc % TD) != 1) cyc(1'b0, 0, 0, 0, acc);
    do_reset();
    for (int k = 0; k < 3 * TD; k++) cyc(1'b0, 0, 0, 0, acc);
    chk("no ramp after reset", 64'(pwm_ctrl0), 64'(NEU));

    // Randomized traffic: busy phase then sparse phase so the watchdog fires.
    do_reset();
    for (int k = 0; k < 800; k++) begin
      int vp;
      vp = (k < 400) ? 2 : 12;
      cyc($urandom_range(vp - 1, 0) == 0, int'($urandom_range(3, 0)), int'($urandom_range(255, 0)),
          int'($urandom_range(15, 0)), acc);
    end
    cmd_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
